bsg_skid_buffer_en: RTL

- Two-entry ready/valid skid buffer that sits directly upstream of a reset/enable data register bank.
- Consumer handshake: v_o/data_o drive the downstream register's en_i/data_i; the consumer asserts yumi_i in the cycle it captures.
- ready_o is a pure function of registered state, so it never combinationally depends on yumi_i. This breaks the ready timing path between producer and consumer.
- Sustains one transfer per cycle.

---
 rtl/bsg_skid_buffer_en.sv | 53 +++++
 1 files changed

// File: rtl/bsg_skid_buffer_en.sv
// bsg_skid_buffer_en: two-entry ready/valid skid buffer feeding an enable register bank
module bsg_skid_buffer_en #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic [1:0]         els_o
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  state_e             r_state;
  logic [width_p-1:0] r_main, r_skid;
  logic               w_in, w_out;
  // ready depends only on registered state, cutting the yumi -> ready path
  assign v_o     = r_state != EMPTY;
  assign ready_o = r_state != TWO;
  assign els_o   = r_state == TWO ? 2'd2 : r_state == ONE ? 2'd1 : 2'd0;
  assign data_o  = r_main;
  assign w_in    = v_i & ready_o;
  assign w_out   = yumi_i & v_o;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        EMPTY: if (w_in) begin
          r_main  <= data_i;
          r_state <= ONE;
        end
        ONE: if (w_in && !w_out) begin
          r_skid  <= data_i;
          r_state <= TWO;
        end else if (w_in) begin
          r_main  <= data_i;
        end else if (w_out) begin
          r_state <= EMPTY;
        end
        TWO: if (w_out) begin
          r_main  <= r_skid;
          r_state <= ONE;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
endmodule
